// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync 1101, then a payload sent MSB-first, with zero
// stuffing so that 1101 appears on the line only at the end of each sync.
//
// state | meaning (describes the bit currently on `out`)
// IDLE  | line idle, out=0
// SYNC  | sync bit sync_idx of 1,1,0,1
// DATA  | payload bit; bits_left counts payload bits not yet sent
// STUFF | inserted zero after a 1,1,0 run
module sync_frame_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              out,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    // Bit i of SYNC_SEQ is the i-th sync bit put on the line.
    localparam logic [3:0] SYNC_SEQ = 4'b1011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        DATA  = 2'd2,
        STUFF = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [1:0]        sync_idx, sync_idx_n;
    logic [CNT_W-1:0]  bits_left, bits_left_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [2:0]        hist, hist_n;
    logic              out_n;

    logic accept;
    logic stuff_due;
    logic payload_left;
    logic do_start;
    logic do_emit;

    // A trailing 1,1,0 would complete 1101 with the next 1, so it gets a stuff.
    assign stuff_due    = (hist == 3'b110);
    assign payload_left = (bits_left != '0);

    assign frame_done = ((state == DATA)  && !stuff_due && !payload_left) ||
                        ((state == STUFF) && !payload_left);
    assign data_ready = (state == IDLE) || frame_done;
    assign busy       = (state != IDLE);
    assign accept     = data_valid && data_ready;

    always_comb begin
        state_n     = state;
        sync_idx_n  = sync_idx;
        bits_left_n = bits_left;
        shreg_n     = shreg;
        out_n       = 1'b0;
        do_start    = 1'b0;
        do_emit     = 1'b0;

        unique case (state)
            IDLE: begin
                do_start = accept;
            end
            SYNC: begin
                if (sync_idx == 2'd3) begin
                    do_emit = 1'b1;
                end else begin
                    sync_idx_n = sync_idx + 2'd1;
                    out_n      = SYNC_SEQ[sync_idx_n];
                end
            end
            DATA: begin
                if (stuff_due) begin
                    state_n = STUFF;
                end else if (payload_left) begin
                    do_emit = 1'b1;
                end else begin
                    do_start = accept;
                    state_n  = IDLE;
                end
            end
            STUFF: begin
                if (payload_left) begin
                    do_emit = 1'b1;
                end else begin
                    do_start = accept;
                    state_n  = IDLE;
                end
            end
        endcase

        if (do_start) begin
            state_n     = SYNC;
            sync_idx_n  = 2'd0;
            bits_left_n = CNT_W'(DATA_W);
            shreg_n     = data_in;
            out_n       = SYNC_SEQ[0];
        end

        if (do_emit) begin
            state_n = DATA;
            out_n   = shreg[DATA_W-1];
            shreg_n = shreg << 1;
            if (payload_left) begin
                bits_left_n = bits_left - 1'b1;
            end
        end
    end

    assign hist_n = {hist[1:0], out_n};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            sync_idx  <= 2'd0;
            bits_left <= '0;
            shreg     <= '0;
            hist      <= 3'b000;
            out       <= 1'b0;
        end else begin
            state     <= state_n;
            sync_idx  <= sync_idx_n;
            bits_left <= bits_left_n;
            shreg     <= shreg_n;
            hist      <= hist_n;
            out       <= out_n;
        end
    end

endmodule
